// File: rtl/display_pkg.sv
// display_pkg: shared types and constants for the 4-digit 7-segment scan controller.
package display_pkg;
    typedef enum logic [1:0] {IDLE, BLANK, DRIVE} estado_t;
    localparam logic [3:0] ANODOS_OFF = 4'b1111;
    localparam int N_DIGITOS = 4;
    localparam logic [3:0] MASCARA_PADRAO = 4'b1011;
endpackage

// File: rtl/varredura_display_if.sv
// varredura_display_if: enable/mask inputs and scan outputs of the display controller.
interface varredura_display_if;
    logic       habilita;
    logic [3:0] mascara_digitos;
    logic [1:0] seletor;
    logic [3:0] anodos;
    logic       blank;
    logic       fim_varredura;
    modport master (output habilita, mascara_digitos, input seletor, anodos, blank, fim_varredura);
    modport slave (input habilita, mascara_digitos, output seletor, anodos, blank, fim_varredura);
endinterface

// File: rtl/varredura_display_proximo_digito.sv
// proximo_digito: next enabled digit strictly above indice, circularly, plus wrap flag.
module proximo_digito
    import display_pkg::*;
(
    input  logic [1:0] indice,
    input  logic [3:0] mascara,
    output logic [1:0] proximo,
    output logic       volta
);
    // Walk from farthest to nearest so the nearest enabled candidate wins; k=4 is indice itself.
    always_comb begin
        proximo = indice;
        for (int k = N_DIGITOS; k >= 1; k--)
            if (mascara[indice + 2'(k)]) proximo = indice + 2'(k);
    end
    assign volta = proximo <= indice;
endmodule

// File: rtl/varredura_display.sv
// varredura_display: multiplexed 7-segment scan with blanking gap and masked-digit skipping.
module varredura_display
    import display_pkg::*;
#(
    parameter int DIV_REFRESH  = 50000,
    parameter int BLANK_CYCLES = 500
) (
    input  logic                 clk,
    input  logic                 reset,
    varredura_display_if.slave   bus
);
    localparam int MAXC = DIV_REFRESH > BLANK_CYCLES ? DIV_REFRESH : BLANK_CYCLES;
    localparam int CW = MAXC > 1 ? $clog2(MAXC) : 1;
    localparam logic [CW-1:0] B_LAST = CW'(BLANK_CYCLES - 1);
    localparam logic [CW-1:0] D_LAST = CW'(DIV_REFRESH - 1);

    estado_t       state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    seletor_q, seletor_d;
    logic [3:0]    anodos_q, anodos_d;
    logic          blank_q, blank_d;
    logic          fim_q, fim_d;
    logic [1:0]    prox;
    logic          volta;

    // From IDLE, searching above index 3 yields the lowest enabled digit.
    proximo_digito u_prox (
        .indice  (state_q == IDLE ? 2'd3 : seletor_q),
        .mascara (bus.mascara_digitos),
        .proximo (prox),
        .volta   (volta)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            seletor_q <= 2'd0;
            anodos_q  <= ANODOS_OFF;
            blank_q   <= 1'b1;
            fim_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            seletor_q <= seletor_d;
            anodos_q  <= anodos_d;
            blank_q   <= blank_d;
            fim_q     <= fim_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        seletor_d = seletor_q;
        if (!bus.habilita) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE: if (|bus.mascara_digitos) begin
                    state_d   = BLANK;
                    seletor_d = prox;
                    cnt_d     = '0;
                end
                BLANK: if (cnt_q == B_LAST) begin
                    state_d = DRIVE;
                    cnt_d   = '0;
                end else cnt_d = cnt_q + 1'b1;
                DRIVE: if (cnt_q == D_LAST) begin
                    state_d   = |bus.mascara_digitos ? BLANK : IDLE;
                    seletor_d = |bus.mascara_digitos ? prox : seletor_q;
                    cnt_d     = '0;
                end else cnt_d = cnt_q + 1'b1;
                default: state_d = IDLE;
            endcase
        end
    end

    // Outputs are precomputed from the next state so they register alongside it.
    always_comb begin
        anodos_d = state_d == DRIVE ? ~(4'b0001 << seletor_d) : ANODOS_OFF;
        blank_d  = state_d != DRIVE;
        fim_d    = state_q == DRIVE && state_d == BLANK && volta;
    end

    assign bus.seletor       = seletor_q;
    assign bus.anodos        = anodos_q;
    assign bus.blank         = blank_q;
    assign bus.fim_varredura = fim_q;
endmodule

// File: tb/tb_varredura_display.sv
// tb_varredura_display: scoreboard bench comparing the scan controller against a slot-level model.
module tb_varredura_display;
    import display_pkg::*;
    localparam int DR = 4;
    localparam int BC = 1;

    typedef struct {
        logic [1:0] sel;
        logic [3:0] an;
        logic       bl;
        logic       fim;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int checks = 0;
    int errors = 0;
    exp_t fila[$];

    // Reference model: mode 0=idle 1=gap 2=lit, 'restante' counts cycles left in the slot.
    int modo = 0;
    int restante = 0;
    int dig = 0;
    bit fim_m = 0;

    varredura_display_if vif ();

    varredura_display #(.DIV_REFRESH(DR), .BLANK_CYCLES(BC)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (vif)
    );

    always #5 clk = ~clk;

    function automatic int menor_habilitado(logic [3:0] m);
        for (int i = 0; i < 4; i++) if (m[i]) return i;
        return 0;
    endfunction

    function automatic int seguinte(int atual, logic [3:0] m);
        for (int k = 1; k <= 4; k++) if (m[(atual + k) % 4]) return (atual + k) % 4;
        return atual;
    endfunction

    task automatic modelo(input logic r, input logic h, input logic [3:0] m);
        exp_t e;
        int novo;
        fim_m = 0;
        if (r) begin
            modo = 0; dig = 0; restante = 0;
        end else if (!h) begin
            modo = 0;
        end else if (modo == 0) begin
            if (m != 0) begin
                modo = 1; restante = BC; dig = menor_habilitado(m);
            end
        end else if (modo == 1) begin
            if (restante == 1) begin modo = 2; restante = DR; end
            else restante--;
        end else begin
            if (restante > 1) restante--;
            else if (m == 0) modo = 0;
            else begin
                novo = seguinte(dig, m);
                fim_m = novo <= dig;
                dig = novo;
                modo = 1;
                restante = BC;
            end
        end
        e.sel = 2'(dig);
        e.an  = modo == 2 ? ~(4'b0001 << dig) : 4'b1111;
        e.bl  = modo != 2;
        e.fim = fim_m;
        fila.push_back(e);
    endtask

    task automatic tick(input logic r, input logic h, input logic [3:0] m);
        @(negedge clk);
        reset = r;
        vif.habilita = h;
        vif.mascara_digitos = m;
        modelo(r, h, m);
    endtask

    task automatic verifica(input string nome, input int atual, input int esperado);
        checks++;
        if (atual != esperado) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", nome, atual, esperado, $time);
        end
    endtask

    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (fila.size() != 0) begin
                e = fila.pop_front();
                verifica("seletor", int'(vif.seletor), int'(e.sel));
                verifica("anodos", int'(vif.anodos), int'(e.an));
                verifica("blank", int'(vif.blank), int'(e.bl));
                verifica("fim_varredura", int'(vif.fim_varredura), int'(e.fim));
                verifica("one_hot_anodo", int'($countones(~vif.anodos) <= 1), 1);
            end
        end
    end

    initial begin
        logic [3:0] m;
        logic h;
        logic r;
        vif.habilita = 1'b0;
        vif.mascara_digitos = 4'b0000;
        repeat (2) tick(1, 0, 4'b0000);
        repeat (45) tick(0, 1, MASCARA_PADRAO);
        tick(1, 0, 4'b0100);
        repeat (20) tick(0, 1, 4'b0100);
        tick(1, 0, 4'b1011);
        repeat (8) tick(0, 1, 4'b1011);
        repeat (10) tick(0, 1, 4'b0000);
        tick(1, 0, 4'b1011);
        repeat (4) tick(0, 1, 4'b1011);
        tick(0, 0, 4'b1011);
        repeat (10) tick(0, 1, 4'b1011);
        tick(1, 0, 4'b1011);
        repeat (13) tick(0, 1, 4'b1011);
        tick(1, 1, 4'b1011);
        repeat (5) tick(0, 1, 4'b1011);
        m = 4'b1011;
        for (int i = 0; i < 1000; i++) begin
            if ($urandom_range(0, 24) == 0) m = 4'($urandom_range(0, 15));
            h = $urandom_range(0, 15) != 0;
            r = $urandom_range(0, 99) == 0;
            tick(r, h, m);
        end
        repeat (3) @(posedge clk);
        #2;
        verifica("scoreboard_drained", fila.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
